// File: rtl/sd_resp_rx.sv
// sd_resp_rx: SD-bus CMD-line response receiver.
// Once armed by a one-cycle start pulse, it hunts for the start bit on the CMD line.
// It then shifts in a short (SHORT_BITS) or long (LONG_BITS) frame MSB-first.
// Completion is reported with a single-cycle resp_valid strobe. The strobe carries
// timeout, framing and (optionally) CRC7 status.
// Optional feature: define SD_RESP_CRC_EN to build the serial CRC7 checker
// (x^7 + x^3 + 1, init 0). Without it crc_err is tied to 0.

module sd_resp_rx #(
    parameter int SHORT_BITS  = 48,
    parameter int LONG_BITS   = 136,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 sd_clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 long_resp,
    input  logic                 no_crc,
    input  logic                 sd_cmd_in,
    output logic                 busy,
    output logic                 resp_valid,
    output logic [LONG_BITS-1:0] resp_data,
    output logic                 timeout,
    output logic                 end_err,
    output logic                 crc_err
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RECV = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 long_q, long_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [7:0]           bit_cnt_q, bit_cnt_d;
    logic [LONG_BITS-1:0] shift_q, shift_d;
    logic                 busy_q, busy_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [LONG_BITS-1:0] resp_data_q, resp_data_d;
    logic                 timeout_q, timeout_d;
    logic                 end_err_q, end_err_d;

    logic                 accept_s;
    logic                 wait_last_s;
    logic [7:0]           last_cnt_s;
    logic                 frame_done_s;
    logic                 tx_bit_s;

`ifdef SD_RESP_CRC_EN
    logic                 no_crc_q, no_crc_d;
    logic [6:0]           crc_q, crc_d;
    logic                 crc_err_q, crc_err_d;
    logic                 crc_window_s;

    // One serial step of the CRC7 generator x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // The CRC spans frame bits (top-of-payload)..8. In RECV, bit_cnt_q = k samples frame bit N-1-k.
    // Long frames skip their 8-bit header. The short start bit is a 0 into a zero CRC, so it is a no-op.
    assign crc_window_s = (bit_cnt_q >= (long_q ? 8'd8 : 8'd1)) &&
                          (bit_cnt_q <= (long_q ? 8'(LONG_BITS - 9) : 8'(SHORT_BITS - 9)));
`else
    logic unused_no_crc_s;
    assign unused_no_crc_s = no_crc;
`endif

    logic unused_shift_msb_s;
    assign unused_shift_msb_s = shift_q[LONG_BITS-1];

    // A start pulse coinciding with the completion strobe is deliberately dropped.
    assign accept_s     = (state_q == S_IDLE) && start && !resp_valid_q;
    assign wait_last_s  = (wait_cnt_q == WAIT_W'(TIMEOUT_CYC - 1));
    assign last_cnt_s   = long_q ? 8'(LONG_BITS - 1) : 8'(SHORT_BITS - 1);
    assign frame_done_s = (state_q == S_RECV) && (bit_cnt_q == last_cnt_s);
    // Transmission bit is frame bit N-2; frame bit j sits at shift_q[j-1] when the end bit arrives.
    assign tx_bit_s     = long_q ? shift_q[LONG_BITS-3] : shift_q[SHORT_BITS-3];

    // State register.
    always_ff @(posedge sd_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: arm, hunt for start bit, receive the frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) state_d = S_WAIT;
                else          state_d = S_IDLE;
            end
            S_WAIT: begin
                if (!sd_cmd_in)       state_d = S_RECV;
                else if (wait_last_s) state_d = S_IDLE;
                else                  state_d = S_WAIT;
            end
            S_RECV: begin
                if (frame_done_s) state_d = S_IDLE;
                else              state_d = S_RECV;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values for each state.
    always_comb begin
        long_d       = long_q;
        wait_cnt_d   = wait_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        busy_d       = busy_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        timeout_d    = 1'b0;
        end_err_d    = 1'b0;
`ifdef SD_RESP_CRC_EN
        no_crc_d     = no_crc_q;
        crc_d        = crc_q;
        crc_err_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (accept_s) begin
                    long_d     = long_resp;
                    wait_cnt_d = '0;
                    bit_cnt_d  = 8'd0;
                    shift_d    = '0;
`ifdef SD_RESP_CRC_EN
                    no_crc_d   = no_crc;
                    crc_d      = 7'd0;
`endif
                end else begin
                    long_d = long_q;
                end
            end
            S_WAIT: begin
                busy_d = 1'b1;
                if (!sd_cmd_in) begin
                    shift_d   = {shift_q[LONG_BITS-2:0], 1'b0};
                    bit_cnt_d = 8'd1;
                end else if (wait_last_s) begin
                    resp_valid_d = 1'b1;
                    timeout_d    = 1'b1;
                    resp_data_d  = '0;
                    busy_d       = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_RECV: begin
                busy_d    = 1'b1;
                shift_d   = {shift_q[LONG_BITS-2:0], sd_cmd_in};
                bit_cnt_d = bit_cnt_q + 8'd1;
`ifdef SD_RESP_CRC_EN
                if (crc_window_s) crc_d = crc7_step(crc_q, sd_cmd_in);
                else              crc_d = crc_q;
`endif
                if (frame_done_s) begin
                    resp_valid_d = 1'b1;
                    busy_d       = 1'b0;
                    resp_data_d  = shift_d;
                    end_err_d    = !sd_cmd_in || tx_bit_s;
`ifdef SD_RESP_CRC_EN
                    crc_err_d    = (crc_q != shift_q[6:0]) && !no_crc_q;
`endif
                end else begin
                    resp_data_d = resp_data_q;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge sd_clk) begin
        if (rst) begin
            long_q       <= 1'b0;
            wait_cnt_q   <= '0;
            bit_cnt_q    <= 8'd0;
            shift_q      <= '0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            timeout_q    <= 1'b0;
            end_err_q    <= 1'b0;
`ifdef SD_RESP_CRC_EN
            no_crc_q     <= 1'b0;
            crc_q        <= 7'd0;
            crc_err_q    <= 1'b0;
`endif
        end else begin
            long_q       <= long_d;
            wait_cnt_q   <= wait_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            timeout_q    <= timeout_d;
            end_err_q    <= end_err_d;
`ifdef SD_RESP_CRC_EN
            no_crc_q     <= no_crc_d;
            crc_q        <= crc_d;
            crc_err_q    <= crc_err_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign timeout    = timeout_q;
    assign end_err    = end_err_q;
`ifdef SD_RESP_CRC_EN
    assign crc_err    = crc_err_q;
`else
    assign crc_err    = 1'b0;
`endif

endmodule
